// File: rtl/ip_hdr_insert.sv
// IPv4 header inserter: pops one payload length per frame, emits a 20-byte
// IPv4 header with computed total length and checksum, then passes the payload through.
module ip_hdr_insert #(
   parameter logic [31:0] SRC_IP  = 32'hC0A8010A,
   parameter logic [31:0] DST_IP  = 32'hC0A80101,
   parameter logic [7:0]  TTL     = 8'h40,
   parameter logic [7:0]  PROTO   = 8'h11,
   parameter logic [15:0] ID_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        len_tvalid,
   output logic        len_tready,
   input  logic [15:0] len_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [7:0]  s_tdata,
   input  logic        s_tlast,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic [7:0]  m_tdata,
   output logic        m_tlast,
   output logic        len_err
);

   localparam int unsigned IDX_W    = 5;
   localparam int unsigned HDR_LAST = 19;
   localparam logic [15:0] LEN_MAX  = 16'd65514;
   localparam logic [15:0] HDR_LEN  = 16'd21;

   typedef enum logic [2:0] {IDLE, SUM, FOLD, HDR, PAY} state_t;

   state_t             state, state_nxt;
   logic [15:0]        id, totlen, len_lat, csum, pay_cnt;
   logic [31:0]        sum;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        sum_c, fold1;
   logic [15:0]        fold2;
   logic [7:0]         hdr_byte;

   // One's-complement header checksum terms (checksum field taken as zero)
   always_comb begin
      sum_c = 32'(16'h4500) + 32'(totlen) + 32'(id) + 32'(16'h4000)
            + 32'({TTL, PROTO})
            + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
            + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
      fold1 = 32'(sum[15:0]) + 32'(sum[31:16]);
      fold2 = fold1[15:0] + fold1[31:16];
   end

   always_comb begin
      case (idx)
         5'd0:    hdr_byte = 8'h45;
         5'd1:    hdr_byte = 8'h00;
         5'd2:    hdr_byte = totlen[15:8];
         5'd3:    hdr_byte = totlen[7:0];
         5'd4:    hdr_byte = id[15:8];
         5'd5:    hdr_byte = id[7:0];
         5'd6:    hdr_byte = 8'h40;
         5'd7:    hdr_byte = 8'h00;
         5'd8:    hdr_byte = TTL;
         5'd9:    hdr_byte = PROTO;
         5'd10:   hdr_byte = csum[15:8];
         5'd11:   hdr_byte = csum[7:0];
         5'd12:   hdr_byte = SRC_IP[31:24];
         5'd13:   hdr_byte = SRC_IP[23:16];
         5'd14:   hdr_byte = SRC_IP[15:8];
         5'd15:   hdr_byte = SRC_IP[7:0];
         5'd16:   hdr_byte = DST_IP[31:24];
         5'd17:   hdr_byte = DST_IP[23:16];
         5'd18:   hdr_byte = DST_IP[15:8];
         5'd19:   hdr_byte = DST_IP[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Handshakes are suppressed while reset is held so nothing is consumed or emitted
   always_comb begin
      state_nxt  = state;
      len_tready = 1'b0;
      s_tready   = 1'b0;
      m_tvalid   = 1'b0;
      m_tdata    = 8'h00;
      m_tlast    = 1'b0;
      len_err    = 1'b0;
      if (rstn) begin
         case (state)
            IDLE: begin
               len_tready = len_tvalid;
               if (len_tvalid) begin
                  state_nxt = SUM;
                  if (len_tdata > LEN_MAX) len_err = 1'b1;
               end
            end
            SUM:  state_nxt = FOLD;
            FOLD: state_nxt = HDR;
            HDR: begin
               m_tvalid = 1'b1;
               m_tdata  = hdr_byte;
               if (m_tready && (idx == IDX_W'(HDR_LAST))) state_nxt = PAY;
            end
            PAY: begin
               m_tvalid = s_tvalid;
               m_tdata  = s_tdata;
               m_tlast  = s_tlast;
               s_tready = m_tready;
               if (s_tvalid && m_tready && s_tlast) begin
                  state_nxt = IDLE;
                  if ((pay_cnt + 16'd1) != (len_lat + 16'd1)) len_err = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath registers: length latch, checksum pipeline, indices and frame id
   always_ff @(posedge clk) begin
      if (!rstn) begin
         id      <= ID_INIT;
         idx     <= '0;
         totlen  <= '0;
         len_lat <= '0;
         sum     <= '0;
         csum    <= '0;
         pay_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (len_tvalid) begin
               totlen  <= len_tdata + HDR_LEN;
               len_lat <= len_tdata;
            end
            SUM:  sum <= sum_c;
            FOLD: begin
               csum    <= ~fold2;
               idx     <= '0;
               pay_cnt <= '0;
            end
            HDR:  if (m_tready) idx <= idx + IDX_W'(1);
            PAY:  if (s_tvalid && m_tready) begin
               pay_cnt <= pay_cnt + 16'd1;
               if (s_tlast) id <= id + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ip_hdr_insert.md
Name: ip_hdr_insert

Overview:
- Sequencer that sits directly after the frame-length measurement stage in the UDP transmit stack.
- For each payload frame it pops one length word, computes the IPv4 total length and header checksum, and emits a 20-byte IPv4 header. It then streams the payload through unchanged until s_tlast.
- Guarantees one header per payload frame, strictly in order, with no header emitted before its length is known.

Parameters:
- SRC_IP, 32'hC0A8010A, IPv4 source address.
- DST_IP, 32'hC0A80101, IPv4 destination address.
- TTL, 8'h40, time-to-live field.
- PROTO, 8'h11, protocol field (UDP).
- ID_INIT, 16'h0000, identification value used for the first frame after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- len_tvalid  in  1  length word available.
- len_tready  out  1  length word consumed.
- len_tdata  in  16  payload byte count minus one (N-byte frame carries N-1).
- s_tvalid  in  1  payload byte valid.
- s_tready  out  1  payload byte accepted.
- s_tdata  in  8  payload byte.
- s_tlast  in  1  last payload byte of frame.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  8  IPv4 header byte followed by payload bytes.
- m_tlast  out  1  last byte of the IP datagram.
- len_err  out  1  one-cycle pulse on a length fault.

Behaviour:
- Reset: clk edge with rstn=0 forces state IDLE, id=ID_INIT, byte index 0, len_err=0. Outputs len_tready, s_tready and m_tvalid are 0. A frame in progress is abandoned and no m_tlast is issued for it.
- States: IDLE -> SUM -> FOLD -> HDR -> PAY -> IDLE.
- IDLE:
  - len_tready = len_tvalid.
  - On handshake, latch totlen = len_tdata + 21 (mod 2^16) and go to SUM.
  - If len_tdata > 16'd65514, pulse len_err the same cycle; the wrapped value is still used.
- SUM:
  - Form the 32-bit sum of 16'h4500, totlen, id, 16'h4000, {TTL,PROTO}, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0].
  - Always go to FOLD.
- FOLD:
  - csum = ~fold(fold(sum)), where fold(x) = x[15:0] + x[31:16].
  - Go to HDR with byte index 0.
- HDR:
  - m_tvalid=1, m_tlast=0, s_tready=0.
  - Bytes 0..19 in order: 45, 00, totlen[15:8], totlen[7:0], id[15:8], id[7:0], 40, 00, TTL, PROTO, csum[15:8], csum[7:0], SRC_IP big-endian (4 bytes), DST_IP big-endian (4 bytes).
  - Index advances only on m_tvalid&m_tready. m_tdata holds stable while m_tready=0.
  - After byte 19 is accepted, go to PAY.
- PAY:
  - Combinational pass-through: m_tvalid=s_tvalid, m_tdata=s_tdata, m_tlast=s_tlast, s_tready=m_tready.
  - A 16-bit payload counter counts accepted bytes.
  - On an accepted s_tlast: if count != latched len_tdata + 1, pulse len_err. Then id <= id+1 (wraps 16'hFFFF -> 0) and go to IDLE.
- Outside PAY: s_tready=0. Outside IDLE: len_tready=0.
- Latency: a length accepted at cycle T gives header byte 0 valid at T+3. A payload byte reaches m_* with 0 cycles latency.
- Payload arriving before its length is held off by s_tready=0; this is normal backpressure, not an error.
- Next frame: at the IDLE handshake, a len_tvalid that is already high is accepted in the first IDLE cycle. The minimum gap between one frame's m_tlast and the next header's byte 0 is 4 cycles.

Test Plan:
- Default parameters, id=0, len_tdata=7, 8 payload bytes 01..08, m_tready=1 -> header 45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01, then 01..08. m_tlast on 08, len_err never set, header byte 0 at 3 cycles after the length handshake.
- Two back-to-back frames, len_tdata=7 then 7 -> second header carries id 00 01 and checksum B7 74.
- Toggle m_tready every other cycle during HDR and PAY -> byte sequence identical to the first case, no duplicated or skipped bytes, m_tdata stable while stalled.
- len_tdata=7 but s_tlast on the 5th byte -> len_err pulses for exactly 1 cycle at that byte. id still increments and the FSM returns to IDLE.
- Payload presented with no length -> s_tready=0 and m_tvalid=0 indefinitely. A length then arrives -> the normal header and payload follow.
- rstn=0 for 1 cycle mid-PAY -> outputs go to reset values on the next edge. id returns to ID_INIT and the next frame header starts at byte 45.
